// File: rtl/write_iq_bytes.sv
// write_iq_bytes
//
// Turns paired 32-bit quantized I/Q samples back into the raw interleaved
// 8-bit IQ byte stream. One I word and one Q word are popped together from two
// FWFT FIFOs. Each is dequantized by an arithmetic right shift with 16-bit
// saturation, then emitted as four little-endian bytes: I_lo, I_hi, Q_lo, Q_hi.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   I_empty    in   I FIFO empty (I_dout valid when low)
//   I_dout     in   I sample, two's complement
//   I_rd_en    out  pop I FIFO
//   Q_empty    in   Q FIFO empty (Q_dout valid when low)
//   Q_dout     in   Q sample, two's complement
//   Q_rd_en    out  pop Q FIFO (always equal to I_rd_en)
//   out_full   in   output byte FIFO full
//   out_wr_en  out  output byte write strobe
//   out_din    out  output byte
module write_iq_bytes #(
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_empty,
    input  logic [DATA_WIDTH-1:0] I_dout,
    output logic                  I_rd_en,
    input  logic                  Q_empty,
    input  logic [DATA_WIDTH-1:0] Q_dout,
    output logic                  Q_rd_en,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [7:0]            out_din
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_B0   = 3'd1;
    localparam logic [2:0] S_B1   = 3'd2;
    localparam logic [2:0] S_B2   = 3'd3;
    localparam logic [2:0] S_B3   = 3'd4;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(32767);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(-32768);

    logic [2:0]  state;
    logic [15:0] i16;
    logic [15:0] q16;

    logic        in_byte;
    logic        both_valid;
    logic        pop;

    // Floor division by 2^QUANT_BITS, clamped to the signed 16-bit range.
    function automatic logic [15:0] dequant(input logic [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0] s;
        s = $signed(x) >>> QUANT_BITS;
        if (s > SAT_MAX) begin
            return 16'h7fff;
        end else if (s < SAT_MIN) begin
            return 16'h8000;
        end else begin
            return s[15:0];
        end
    endfunction

    always_comb begin
        in_byte    = (state != S_IDLE);
        both_valid = !I_empty && !Q_empty;
        // Gating with reset keeps a half-emitted pair from leaking its next
        // byte during the reset cycle.
        out_wr_en  = in_byte && !out_full && !reset;
        pop        = both_valid && !reset &&
                     ((state == S_IDLE) || ((state == S_B3) && out_wr_en));
        I_rd_en    = pop;
        Q_rd_en    = pop;
    end

    // Register-only mux: no path from I_dout/Q_dout to out_din.
    always_comb begin
        out_din = 8'h00;
        unique case (state)
            S_B0:    out_din = i16[7:0];
            S_B1:    out_din = i16[15:8];
            S_B2:    out_din = q16[7:0];
            S_B3:    out_din = q16[15:8];
            default: out_din = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            i16   <= 16'h0000;
            q16   <= 16'h0000;
        end else if (pop) begin
            // Covers both the idle start and the seamless S_B3 -> S_B0 reload.
            i16   <= dequant(I_dout);
            q16   <= dequant(Q_dout);
            state <= S_B0;
        end else if (out_wr_en) begin
            unique case (state)
                S_B0:    state <= S_B1;
                S_B1:    state <= S_B2;
                S_B2:    state <= S_B3;
                S_B3:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/write_iq_bytes.md
# write_iq_bytes

Serializer that converts paired 32-bit quantized I/Q samples back into the raw interleaved 8-bit IQ byte stream. It reads one I and one Q word from two FWFT FIFOs and dequantizes each by an arithmetic right shift with 16-bit saturation. It then emits four bytes per pair, little-endian, in the order I_lo, I_hi, Q_lo, Q_hi, into a byte FIFO. It sits at the output of the IQ path, is the exact inverse of the byte-to-IQ reader, and is used for loopback and for the byte-stream export path.

## Interface
- DATA_WIDTH, 32, width of the I/Q sample words
- QUANT_BITS, 10, fractional bits removed on dequantization (arithmetic right shift amount)
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- I_empty  in  1  I FIFO empty; I_dout valid whenever low (FWFT)
- I_dout  in  DATA_WIDTH  I sample, two's complement
- I_rd_en  out  1  pop I FIFO
- Q_empty  in  1  Q FIFO empty; Q_dout valid whenever low (FWFT)
- Q_dout  in  DATA_WIDTH  Q sample, two's complement
- Q_rd_en  out  1  pop Q FIFO
- out_full  in  1  output byte FIFO full
- out_wr_en  out  1  write strobe to output byte FIFO
- out_din  out  8  byte to output FIFO

## Operation
- State machine states: S_IDLE, S_B0, S_B1, S_B2, S_B3.
- **Pop:** I_rd_en and Q_rd_en are always identical and asserted together. A pop happens only when I_empty=0 and Q_empty=0. It is allowed only in S_IDLE, or in S_B3 in the same cycle that byte 3 is written.
- **Pop with one side empty:** if only one FIFO is non-empty, nothing is popped and nothing is written.
- **Capture on pop:** in the pop cycle, I_dout and Q_dout are dequantized and registered as 16-bit i16 and q16. The FSM then goes to S_B0.
- **Dequantize:** s = sample >>> QUANT_BITS, which truncates toward negative infinity.
  - If s > 32767, the result is 0x7FFF.
  - If s < -32768, the result is 0x8000.
  - Otherwise the result is s[15:0].
- **Byte states:** out_wr_en = (state in S_B0..S_B3) && !out_full.
  - S_B0 emits i16[7:0].
  - S_B1 emits i16[15:8].
  - S_B2 emits q16[7:0].
  - S_B3 emits q16[15:8].
- **Advance and backpressure:** the FSM advances only on a cycle with out_wr_en=1. While out_full=1 it holds its state and its byte.
- **Leaving S_B3 after a write:**
  - If the pop condition also holds, the FSM pops the next pair and goes to S_B0.
  - Otherwise it goes to S_IDLE.
- **Reset:** state goes to S_IDLE and i16/q16 are cleared to 0. Any partially emitted pair is discarded; no further bytes of it are emitted.

## Timing
- **Reset values:**
  - I_rd_en=0, Q_rd_en=0, out_wr_en=0.
  - out_din=0x00; out_din is 0x00 whenever the state is S_IDLE.
- **Combinational outputs:** out_wr_en, I_rd_en and Q_rd_en are combinational from the state, out_full and the empty flags. out_din is a mux of registers; there is no combinational path from I_dout or Q_dout to out_din.
- **Latency:** if the pop happens in cycle N, byte 0 is written in cycle N+1 when out_full=0.
- **Throughput:** with no stall, one byte per cycle. Back-to-back pairs produce a continuous byte stream with no idle cycles.
- **Startup cost:** the first pair after S_IDLE costs one extra cycle (the pop cycle).
- **Output contract:** the block never writes while out_full=1.
- **Input contract:** the block never pops while either empty flag is 1.

## Test plan
- Pair I=0x00000400, Q=0xFFFFFC00 preloaded: pop, then next 4 cycles write 01 00 FF FF; rd_en high exactly 1 cycle.
- Saturation: I=0x7FFFFFFF, Q=0x80000000 -> bytes FF 7F 00 80; I=0xFFFFFFFF, Q=0x000003FF -> FF FF 00 00 (floor truncation).
- Streaming: 4 pairs preloaded, out_full=0 -> 16 bytes on 16 consecutive cycles starting 1 cycle after first pop; 4 pops, second pop coincident with byte 3 of pair 1.
- Backpressure: out_full=1 for 3 cycles while in S_B2 -> no writes, out_din stable at q16[7:0], no pop; resumes with byte 2 then byte 3.
- Unbalanced inputs: I non-empty, Q empty for 10 cycles -> no rd_en, no wr_en. Then Q is filled -> normal pop and 4 bytes.
- Reset mid-operation: reset asserted in S_B1 -> next cycle all outputs 0, no remaining bytes of that pair emitted. Loopback: iq_raw.txt through byte-to-IQ reader and this block reproduces the input bytes exactly (zero mismatches).
